dnn_result_reader: RTL and testbench

//  Host-side controller for the inference engine's start/done and out_idx/out result port.
//  On a request it clears the engine, then starts it, then waits for done.
//  It then reads the class scores one index per cycle, computes the signed argmax and reports it.

---
 rtl/dnn_result_reader_if.sv | 18 +
 rtl/dnn_result_reader.sv | 101 ++++++++++
 tb/tb_dnn_result_reader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/dnn_result_reader_if.sv
// dnn_result_reader_if: engine-side control/result port of the inference engine.
//   dnn_reset  controller -> engine  one-cycle clear pulse
//   dnn_start  controller -> engine  one-cycle start pulse
//   dnn_done   engine -> controller  inference complete (level or pulse)
//   out_idx    controller -> engine  score select
//   out_data   engine -> controller  signed score for out_idx, same cycle
interface dnn_result_reader_if #(
    parameter int DATA_WIDTH = 5,
    parameter int IDX_WIDTH  = 4
);
    logic                         dnn_reset;
    logic                         dnn_start;
    logic                         dnn_done;
    logic [IDX_WIDTH-1:0]         out_idx;
    logic signed [DATA_WIDTH-1:0] out_data;
    modport master (output dnn_reset, dnn_start, out_idx, input dnn_done, out_data);
    modport slave  (input dnn_reset, dnn_start, out_idx, output dnn_done, out_data);
endinterface

// File: rtl/dnn_result_reader.sv
// dnn_result_reader: clears and starts the inference engine, waits for done, scans the
// class scores and reports the signed argmax (or a timeout).
//   clk, rst      clock, asynchronous active-high reset
//   req           run one inference (sampled only while idle)
//   ready         high while idle
//   eng           engine port (dnn_reset, dnn_start, dnn_done, out_idx, out_data)
//   result_valid  one-cycle pulse when result_idx/result_val/result_err update
//   result_idx    argmax class, held
//   result_val    signed max score, held
//   result_err    timeout flag, held
module dnn_result_reader #(
    parameter int DATA_WIDTH     = 5,
    parameter int NUM_CLASSES    = 10,
    parameter int IDX_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req,
    output logic                         ready,
    dnn_result_reader_if.master          eng,
    output logic                         result_valid,
    output logic [IDX_WIDTH-1:0]         result_idx,
    output logic signed [DATA_WIDTH-1:0] result_val,
    output logic                         result_err
);
    localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, START, WAIT, SCAN, REPORT} state_t;

    state_t                       state, state_nxt;
    logic [CW-1:0]                cnt;
    logic [IDX_WIDTH-1:0]         k;
    logic signed [DATA_WIDTH-1:0] best_val, best_val_nxt;
    logic [IDX_WIDTH-1:0]         best_idx, best_idx_nxt;
    logic                         take, last, timeout;

    assign ready         = state == IDLE;
    assign eng.dnn_reset = state == CLEAR;
    assign eng.dnn_start = state == START;
    assign result_valid  = state == REPORT;
    assign eng.out_idx   = state == SCAN ? k : '0;

    // First score seeds the running best; later ones replace it only when strictly larger,
    // so ties keep the lowest index.
    assign take         = k == '0 || eng.out_data > best_val;
    assign best_val_nxt = take ? eng.out_data : best_val;
    assign best_idx_nxt = take ? k : best_idx;
    assign last         = k == IDX_WIDTH'(NUM_CLASSES - 1);
    assign timeout      = cnt == CW'(TIMEOUT_CYCLES - 1);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = req ? CLEAR : IDLE;
            CLEAR:   state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    state_nxt = eng.dnn_done ? SCAN : timeout ? REPORT : WAIT;
            SCAN:    state_nxt = last ? REPORT : SCAN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            k          <= '0;
            best_val   <= '0;
            best_idx   <= '0;
            result_idx <= '0;
            result_val <= '0;
            result_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == START) begin
                cnt <= '0;
                k   <= '0;
            end
            if (state == WAIT && !eng.dnn_done) begin
                cnt <= cnt + 1'b1;
                if (timeout) begin
                    result_idx <= '0;
                    result_val <= '0;
                    result_err <= 1'b1;
                end
            end
            // Results load on the final scan edge so they are visible during REPORT.
            if (state == SCAN) begin
                k        <= k + 1'b1;
                best_val <= best_val_nxt;
                best_idx <= best_idx_nxt;
                if (last) begin
                    result_idx <= best_idx_nxt;
                    result_val <= best_val_nxt;
                    result_err <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_dnn_result_reader.sv
// tb_dnn_result_reader: directed bench for dnn_result_reader with a score-table engine model
// and a second short-timeout instance whose engine never reports done.
module tb_dnn_result_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req = 1'b0;
    logic done = 1'b0;
    logic ready, result_valid, result_err;
    logic [3:0] result_idx;
    logic signed [4:0] result_val;
    logic signed [4:0] scores [16];

    logic req_to = 1'b0;
    logic ready_to, valid_to, err_to;
    logic [3:0] idx_to;
    logic signed [4:0] val_to;

    int checks = 0;
    int passed = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dnn_result_reader_if #(.DATA_WIDTH(5), .IDX_WIDTH(4)) bus ();
    dnn_result_reader_if #(.DATA_WIDTH(5), .IDX_WIDTH(4)) bus_to ();

    assign bus.dnn_done    = done;
    assign bus.out_data    = scores[bus.out_idx];
    assign bus_to.dnn_done = 1'b0;
    assign bus_to.out_data = 5'sd0;

    dnn_result_reader u_dut (
        .clk(clk), .rst(rst), .req(req), .ready(ready), .eng(bus),
        .result_valid(result_valid), .result_idx(result_idx),
        .result_val(result_val), .result_err(result_err)
    );

    dnn_result_reader #(.TIMEOUT_CYCLES(16)) u_to (
        .clk(clk), .rst(rst), .req(req_to), .ready(ready_to), .eng(bus_to),
        .result_valid(valid_to), .result_idx(idx_to),
        .result_val(val_to), .result_err(err_to)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input int s0, s1, s2, s3, s4, s5, s6, s7, s8, s9);
        int v [10];
        v = '{s0, s1, s2, s3, s4, s5, s6, s7, s8, s9};
        for (int i = 0; i < 16; i++) scores[i] = i < 10 ? 5'(v[i]) : 5'sd0;
    endtask

    // Runs one inference cycle-exactly and leaves the bench #1 into the REPORT cycle.
    task automatic run(input string tag, input int delay, input bit extra_req);
        req = 1'b1;
        tick();
        req = 1'b0;
        check({tag, " clear"}, bus.dnn_reset, 1);
        check({tag, " no start in clear"}, bus.dnn_start, 0);
        tick();
        check({tag, " start"}, bus.dnn_start, 1);
        check({tag, " no clear in start"}, bus.dnn_reset, 0);
        tick();
        check({tag, " busy"}, ready, 0);
        for (int i = 0; i < delay - 1; i++) begin
            req = extra_req && i == 2;
            tick();
            req = 1'b0;
            if (extra_req && i == 2) begin
                check({tag, " req ignored no clear"}, bus.dnn_reset, 0);
                check({tag, " req ignored busy"}, ready, 0);
            end
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check({tag, " out_idx"}, bus.out_idx, k);
            check({tag, " no valid in scan"}, result_valid, 0);
            tick();
        end
        check({tag, " result_valid"}, result_valid, 1);
    endtask

    task automatic expect_result(input string tag, input int idx, input int val);
        check({tag, " idx"}, result_idx, idx);
        check({tag, " val"}, result_val, val);
        check({tag, " err"}, result_err, 0);
        tick();
        check({tag, " valid drops"}, result_valid, 0);
        check({tag, " ready back"}, ready, 1);
        check({tag, " idx held"}, result_idx, idx);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) scores[i] = 5'sd0;
        #1;
        check("reset ready", ready, 1);
        check("reset valid", result_valid, 0);
        check("reset dnn_reset", bus.dnn_reset, 0);
        check("reset dnn_start", bus.dnn_start, 0);
        check("reset out_idx", bus.out_idx, 0);
        check("reset idx", result_idx, 0);
        check("reset val", result_val, 0);
        check("reset err", result_err, 0);
        tick();
        rst = 1'b0;
        tick();

        load(-3, 2, 7, 1, 0, -16, 5, 7, -1, 4);
        run("t1", 20, 1'b0);
        expect_result("t1", 2, 7);

        load(-16, -16, -16, -16, -16, -16, -16, -16, -16, -16);
        run("t2a", 3, 1'b0);
        expect_result("t2a", 0, -16);

        load(15, 15, 15, 15, 15, 15, 15, 15, 15, 15);
        run("t2b", 1, 1'b0);
        expect_result("t2b", 0, 15);

        load(14, -1, 3, 14, 0, 2, -7, 5, 1, 15);
        run("t3", 5, 1'b0);
        expect_result("t3", 9, 15);

        load(-4, 6, 6, -9, 3, 0, 1, -2, 5, 2);
        run("t5", 8, 1'b1);
        expect_result("t5", 1, 6);

        req_to = 1'b1;
        tick();
        req_to = 1'b0;
        n = 1;
        while (!valid_to && n < 40) begin
            tick();
            n++;
        end
        check("t4 timeout latency", n, 19);
        check("t4 valid", valid_to, 1);
        check("t4 err", err_to, 1);
        check("t4 idx", idx_to, 0);
        check("t4 val", val_to, 0);
        tick();
        check("t4 ready back", ready_to, 1);
        check("t4 valid drops", valid_to, 0);

        load(5, 1, 2, 3, 4, 6, 7, 8, 9, 10);
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("t6 ready", ready, 1);
        check("t6 out_idx", bus.out_idx, 0);
        check("t6 dnn_reset", bus.dnn_reset, 0);
        check("t6 dnn_start", bus.dnn_start, 0);
        check("t6 valid", result_valid, 0);
        check("t6 idx", result_idx, 0);
        check("t6 val", result_val, 0);
        check("t6 err", result_err, 0);
        tick();
        rst = 1'b0;
        tick();
        load(-5, -5, -5, -5, -2, -5, -5, -5, -5, -5);
        run("t6b", 2, 1'b0);
        expect_result("t6b", 4, -2);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
